// File: rtl/ex_mem_wb_pipe_if.sv
// Data-memory port bundle between the EX/MEM/WB pipeline block and the data memory.
//   mem_addr  : word address (EX/MEM ALU result)
//   mem_wdata : store data
//   mem_re    : load strobe
//   mem_we    : store strobe, held for the full length of a memory stall
//   mem_stall : memory not ready this cycle
//   mem_rdata : load data, sampled on the edge that ends the access
// master = pipeline side, slave = memory side.
interface ex_mem_wb_pipe_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_re;
  logic        mem_we;
  logic        mem_stall;
  logic [31:0] mem_rdata;

  modport master (
    output mem_addr, mem_wdata, mem_re, mem_we,
    input  mem_stall, mem_rdata
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_re, mem_we,
    output mem_stall, mem_rdata
  );
endinterface

// File: rtl/ex_mem_wb_pipe.sv
// EX/MEM and MEM/WB pipeline registers feeding the EX forwarding unit.
// Inputs : clk, rst_n (async, active low), EX-stage instruction fields
//          (ex_valid, ex_answer, ex_register, ex_regwrite, ex_memread,
//          ex_memwrite, ex_fbout, ex_alink, ex_pc8), flush, ID sources
//          id_rs/id_rt, and the data-memory port dmem (master side).
// Outputs: EX/MEM and MEM/WB forward sources (register, write enable,
//          value), register-file write port wb_we/wb_addr/wb_data,
//          pipe_hold (memory stall) and load_use_stall toward IF/ID.
module ex_mem_wb_pipe #(
  parameter logic [4:0] LINK_REG = 5'd31
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ex_valid,
  input  logic [31:0]             ex_answer,
  input  logic [4:0]              ex_register,
  input  logic                    ex_regwrite,
  input  logic                    ex_memread,
  input  logic                    ex_memwrite,
  input  logic [31:0]             ex_fbout,
  input  logic                    ex_alink,
  input  logic [31:0]             ex_pc8,
  input  logic                    flush,
  input  logic [4:0]              id_rs,
  input  logic [4:0]              id_rt,
  ex_mem_wb_pipe_if.master        dmem,
  output logic [4:0]              EX_MEM_RegisterRdRt,
  output logic                    EX_MEM_RegWrite,
  output logic [31:0]             ex_mem_value,
  output logic [4:0]              MEM_WB_RegisterRdRt,
  output logic                    MEM_WB_RegWrite,
  output logic [31:0]             mem_wb_value,
  output logic                    wb_we,
  output logic [4:0]              wb_addr,
  output logic [31:0]             wb_data,
  output logic                    pipe_hold,
  output logic                    load_use_stall
);

  // A link register configured as r0 must never produce a write.
  localparam logic LINK_OK = (LINK_REG != 5'd0);

  logic        em_valid, em_regwrite, em_memread, em_memwrite;
  logic [4:0]  em_reg;
  logic [31:0] em_value, em_fbout;

  logic        mw_valid, mw_regwrite;
  logic [4:0]  mw_reg;
  logic [31:0] mw_value;

  logic        ex_dest_ok;

  assign ex_dest_ok = (ex_register != '0) & (LINK_OK | ~ex_alink);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      em_valid    <= 1'b0;
      em_regwrite <= 1'b0;
      em_memread  <= 1'b0;
      em_memwrite <= 1'b0;
      em_reg      <= '0;
      em_value    <= '0;
      em_fbout    <= '0;
      mw_valid    <= 1'b0;
      mw_regwrite <= 1'b0;
      mw_reg      <= '0;
      mw_value    <= '0;
    end else begin
      // MEM/WB: a stalled memory access produces a bubble so each
      // instruction reaches writeback for exactly one cycle.
      if (dmem.mem_stall) begin
        mw_valid    <= 1'b0;
        mw_regwrite <= 1'b0;
        mw_reg      <= '0;
        mw_value    <= '0;
      end else begin
        mw_valid    <= em_valid;
        mw_regwrite <= em_regwrite;
        mw_reg      <= em_reg;
        mw_value    <= em_memread ? dmem.mem_rdata : em_value;
      end

      // EX/MEM: a memory stall freezes the stage and takes priority over flush.
      if (!dmem.mem_stall) begin
        if (flush || !ex_valid) begin
          em_valid    <= 1'b0;
          em_regwrite <= 1'b0;
          em_memread  <= 1'b0;
          em_memwrite <= 1'b0;
          em_reg      <= '0;
          em_value    <= '0;
          em_fbout    <= '0;
        end else begin
          em_valid    <= 1'b1;
          em_regwrite <= ex_regwrite & ex_dest_ok;
          em_memread  <= ex_memread;
          em_memwrite <= ex_memwrite;
          em_reg      <= ex_register;
          em_value    <= ex_alink ? ex_pc8 : ex_answer;
          em_fbout    <= ex_fbout;
        end
      end
    end
  end

  assign dmem.mem_addr  = em_value;
  assign dmem.mem_wdata = em_fbout;
  assign dmem.mem_re    = em_valid & em_memread;
  assign dmem.mem_we    = em_valid & em_memwrite;

  // A load's EX/MEM value is its address, so it is not a forward source.
  assign EX_MEM_RegisterRdRt = em_reg;
  assign EX_MEM_RegWrite     = em_valid & em_regwrite & ~em_memread;
  assign ex_mem_value        = em_value;

  assign MEM_WB_RegisterRdRt = mw_reg;
  assign MEM_WB_RegWrite     = mw_valid & mw_regwrite;
  assign mem_wb_value        = mw_value;

  assign wb_we   = MEM_WB_RegWrite;
  assign wb_addr = MEM_WB_RegisterRdRt;
  assign wb_data = mem_wb_value;

  // Combinational outputs are gated by rst_n so every output is 0 in reset.
  assign pipe_hold      = rst_n & dmem.mem_stall;
  assign load_use_stall = rst_n & ex_valid & ex_memread & ex_regwrite & ~flush &
                          (ex_register != '0) &
                          ((ex_register == id_rs) | (ex_register == id_rt));

endmodule

// File: tb/tb_ex_mem_wb_pipe.sv
module tb_ex_mem_wb_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_alink, flush;
  logic [31:0] ex_answer, ex_fbout, ex_pc8;
  logic [4:0]  ex_register, id_rs, id_rt;
  logic [4:0]  EX_MEM_RegisterRdRt, MEM_WB_RegisterRdRt, wb_addr;
  logic        EX_MEM_RegWrite, MEM_WB_RegWrite, wb_we, pipe_hold, load_use_stall;
  logic [31:0] ex_mem_value, mem_wb_value, wb_data;

  ex_mem_wb_pipe_if dmem_if ();

  ex_mem_wb_pipe #(.LINK_REG(5'd31)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_answer(ex_answer), .ex_register(ex_register),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_fbout(ex_fbout), .ex_alink(ex_alink), .ex_pc8(ex_pc8), .flush(flush),
    .id_rs(id_rs), .id_rt(id_rt), .dmem(dmem_if),
    .EX_MEM_RegisterRdRt(EX_MEM_RegisterRdRt), .EX_MEM_RegWrite(EX_MEM_RegWrite),
    .ex_mem_value(ex_mem_value), .MEM_WB_RegisterRdRt(MEM_WB_RegisterRdRt),
    .MEM_WB_RegWrite(MEM_WB_RegWrite), .mem_wb_value(mem_wb_value),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .pipe_hold(pipe_hold), .load_use_stall(load_use_stall)
  );

  typedef struct packed {
    logic        v, rw, mr, mw, al, fl, st;
    logic [4:0]  rd, rs, rt;
    logic [31:0] ans, fb, pc8, rdata;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic        e_lus, e_emrw;
    logic [31:0] e_emval;
    logic        e_wbwe;
    logic [31:0] e_wbdata;
  } vec_t;

  // Reference model: one abstract instruction record per pipeline slot.
  typedef struct packed {
    logic        v, we, ld, sw;
    logic [4:0]  dst;
    logic [31:0] val, fb;
  } slot_t;

  slot_t em, mw;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic stim_t ins(input logic v, rw, mr, mw_, al, fl,
                                input logic [4:0] rd, rs, rt,
                                input logic [31:0] ans, fb, pc8);
    stim_t s;
    s = '{v:v, rw:rw, mr:mr, mw:mw_, al:al, fl:fl, st:1'b0, rd:rd, rs:rs, rt:rt,
          ans:ans, fb:fb, pc8:pc8, rdata:32'hCAFEF00D};
    return s;
  endfunction

  function automatic stim_t idle(input logic st);
    stim_t s;
    s = ins(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    s.st = st;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    ex_valid = s.v; ex_regwrite = s.rw; ex_memread = s.mr; ex_memwrite = s.mw;
    ex_alink = s.al; flush = s.fl; ex_register = s.rd; id_rs = s.rs; id_rt = s.rt;
    ex_answer = s.ans; ex_fbout = s.fb; ex_pc8 = s.pc8;
    dmem_if.mem_stall = s.st; dmem_if.mem_rdata = s.rdata;
  endtask

  task automatic check_all();
    logic lus;
    lus = ex_valid && ex_memread && ex_regwrite && !flush && ex_register != 0 &&
          (ex_register == id_rs || ex_register == id_rt);
    chk("mem_addr", dmem_if.mem_addr, em.val);
    chk("mem_wdata", dmem_if.mem_wdata, em.fb);
    chk("mem_re", {31'b0, dmem_if.mem_re}, {31'b0, em.v && em.ld});
    chk("mem_we", {31'b0, dmem_if.mem_we}, {31'b0, em.v && em.sw});
    chk("em_rdrt", {27'b0, EX_MEM_RegisterRdRt}, {27'b0, em.dst});
    chk("em_rw", {31'b0, EX_MEM_RegWrite}, {31'b0, em.v && em.we && !em.ld});
    chk("em_val", ex_mem_value, em.val);
    chk("mw_rdrt", {27'b0, MEM_WB_RegisterRdRt}, {27'b0, mw.dst});
    chk("mw_rw", {31'b0, MEM_WB_RegWrite}, {31'b0, mw.v && mw.we});
    chk("mw_val", mem_wb_value, mw.val);
    chk("wb_we", {31'b0, wb_we}, {31'b0, mw.v && mw.we});
    chk("wb_addr", {27'b0, wb_addr}, {27'b0, mw.dst});
    chk("wb_data", wb_data, mw.val);
    chk("pipe_hold", {31'b0, pipe_hold}, {31'b0, dmem_if.mem_stall});
    chk("lus", {31'b0, load_use_stall}, {31'b0, lus});
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_addr"}, dmem_if.mem_addr, 0);
    chk({tag, "_wdata"}, dmem_if.mem_wdata, 0);
    chk({tag, "_re_we"}, {30'b0, dmem_if.mem_re, dmem_if.mem_we}, 0);
    chk({tag, "_em"}, {26'b0, EX_MEM_RegWrite, EX_MEM_RegisterRdRt}, 0);
    chk({tag, "_emval"}, ex_mem_value, 0);
    chk({tag, "_mw"}, {26'b0, MEM_WB_RegWrite, MEM_WB_RegisterRdRt}, 0);
    chk({tag, "_mwval"}, mem_wb_value, 0);
    chk({tag, "_wb"}, {26'b0, wb_we, wb_addr}, 0);
    chk({tag, "_wbdata"}, wb_data, 0);
    chk({tag, "_stalls"}, {30'b0, pipe_hold, load_use_stall}, 0);
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_step();
    slot_t nx;
    if (dmem_if.mem_stall) begin
      mw = '0;
    end else begin
      mw = em;
      if (em.ld) mw.val = dmem_if.mem_rdata;
      if (flush || !ex_valid) begin
        em = '0;
      end else begin
        nx.v   = 1'b1;
        nx.we  = ex_regwrite && ex_register != 0;
        nx.ld  = ex_memread;
        nx.sw  = ex_memwrite;
        nx.dst = ex_register;
        nx.val = ex_alink ? ex_pc8 : ex_answer;
        nx.fb  = ex_fbout;
        em = nx;
      end
    end
  endtask

  // Drive at the falling edge, check mid-cycle, update the model on the rising edge.
  task automatic cyc(input stim_t s);
    @(negedge clk);
    drive(s);
    #1 check_all();
    @(posedge clk);
    model_step();
  endtask

  vec_t vt[10];
  stim_t rs;

  initial begin
    em = '0;
    mw = '0;

    // Reset with active-looking inputs: everything must read 0.
    rs = ins(1, 1, 1, 1, 0, 0, 5'd8, 5'd8, 5'd0, 32'h11, 32'h22, 32'h33);
    rs.st = 1'b1;
    drive(rs);
    #2 check_zero("reset");
    #5 rst_n = 1'b1;

    vt[0] = '{ins(1,1,0,0,0,0,5'd5,5'd0,5'd0,32'h12,0,0),       0,1,32'h12,1,32'h12};
    vt[1] = '{ins(1,1,1,0,0,0,5'd8,5'd8,5'd1,32'h200,0,0),      1,0,32'h200,1,32'hCAFEF00D};
    vt[2] = '{ins(1,1,1,0,0,1,5'd8,5'd1,5'd8,32'h204,0,0),      0,0,32'h0,0,32'h0};
    vt[3] = '{ins(1,1,1,0,0,0,5'd0,5'd0,5'd0,32'h300,0,0),      0,0,32'h300,0,32'hCAFEF00D};
    vt[4] = '{ins(1,1,0,0,1,0,5'd31,5'd2,5'd3,32'h1234,0,32'h400008), 0,1,32'h400008,1,32'h400008};
    vt[5] = '{ins(1,1,0,0,0,0,5'd0,5'd0,5'd0,32'h55,0,0),       0,0,32'h55,0,32'h55};
    vt[6] = '{ins(1,0,0,1,0,0,5'd4,5'd4,5'd4,32'h100,32'hDEAD,0), 0,0,32'h100,0,32'h100};
    vt[7] = '{ins(0,1,1,0,0,0,5'd7,5'd7,5'd7,32'h77,0,0),       0,0,32'h0,0,32'h0};
    vt[8] = '{ins(1,1,1,0,0,0,5'd9,5'd3,5'd9,32'h44,0,0),       1,0,32'h44,1,32'hCAFEF00D};
    vt[9] = '{ins(1,0,1,0,0,0,5'd9,5'd9,5'd9,32'h48,0,0),       0,0,32'h48,0,32'hCAFEF00D};

    for (int i = 0; i < 10; i++) begin
      cyc(vt[i].s);
      #2;
      chk($sformatf("v%0d_lus", i), {31'b0, load_use_stall}, {31'b0, vt[i].e_lus});
      chk($sformatf("v%0d_emrw", i), {31'b0, EX_MEM_RegWrite}, {31'b0, vt[i].e_emrw});
      chk($sformatf("v%0d_emval", i), ex_mem_value, vt[i].e_emval);
      cyc(idle(0));
      #2;
      chk($sformatf("v%0d_wbwe", i), {31'b0, wb_we}, {31'b0, vt[i].e_wbwe});
      chk($sformatf("v%0d_wbdata", i), wb_data, vt[i].e_wbdata);
      cyc(idle(0));
      #2 chk($sformatf("v%0d_wbwe_once", i), {31'b0, wb_we}, 0);
    end

    // Load-use: address on the port, no forward, loaded data written back to r8.
    cyc(ins(1,1,1,0,0,0,5'd8,5'd8,5'd2,32'h0000_0A00,0,0));
    #2;
    chk("lu_stall", {31'b0, load_use_stall}, 1);
    chk("lu_emrw", {31'b0, EX_MEM_RegWrite}, 0);
    chk("lu_re", {31'b0, dmem_if.mem_re}, 1);
    chk("lu_addr", dmem_if.mem_addr, 32'h0000_0A00);
    cyc(idle(0));
    #2;
    chk("lu_mwval", mem_wb_value, 32'hCAFEF00D);
    chk("lu_wbaddr", {27'b0, wb_addr}, 8);

    // Store held through a 3-cycle memory stall; MEM/WB bubbles meanwhile.
    cyc(ins(1,0,0,1,0,0,5'd6,5'd0,5'd0,32'h180,32'hBEEF,0));
    for (int k = 0; k < 3; k++) begin
      cyc(idle(1));
      #2;
      chk($sformatf("st%0d_we", k), {31'b0, dmem_if.mem_we}, 1);
      chk($sformatf("st%0d_wdata", k), dmem_if.mem_wdata, 32'hBEEF);
      chk($sformatf("st%0d_wbwe", k), {31'b0, wb_we}, 0);
      chk($sformatf("st%0d_hold", k), {31'b0, pipe_hold}, 1);
    end
    cyc(idle(0));
    #2 chk("st_done_we", {31'b0, dmem_if.mem_we}, 0);

    // Flush together with a stall: the stall wins and EX/MEM keeps r3.
    cyc(ins(1,1,0,0,0,0,5'd3,5'd0,5'd0,32'h33,0,0));
    rs = ins(1,1,0,0,0,1,5'd9,5'd0,5'd0,32'h99,0,0);
    rs.st = 1'b1;
    cyc(rs);
    #2;
    chk("fs_rdrt", {27'b0, EX_MEM_RegisterRdRt}, 3);
    chk("fs_val", ex_mem_value, 32'h33);
    cyc(idle(0));
    cyc(idle(0));

    // Reset mid-stream, between edges.
    cyc(ins(1,1,0,0,0,0,5'd5,5'd0,5'd0,32'h12,0,0));
    #2 rst_n = 1'b0;
    #1 check_zero("midrst");
    em = '0;
    mw = '0;
    #1 rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cyc(idle(0));
      #2 chk($sformatf("midrst_wbwe%0d", k), {31'b0, wb_we}, 0);
    end

    // Randomised traffic against the model.
    for (int n = 0; n < 400; n++) begin
      rs.v     = ($urandom_range(0, 3) != 0);
      rs.rw    = $urandom_range(0, 1);
      rs.mr    = ($urandom_range(0, 2) == 0);
      rs.mw    = !rs.mr && ($urandom_range(0, 3) == 0);
      rs.al    = ($urandom_range(0, 7) == 0);
      rs.fl    = ($urandom_range(0, 7) == 0);
      rs.st    = ($urandom_range(0, 3) == 0);
      rs.rd    = rs.al ? 5'd31 : 5'(($urandom_range(0, 7)));
      rs.rs    = 5'($urandom_range(0, 7));
      rs.rt    = 5'($urandom_range(0, 7));
      rs.ans   = $urandom;
      rs.fb    = $urandom;
      rs.pc8   = $urandom;
      rs.rdata = $urandom;
      cyc(rs);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
